// File: rtl/axi_mem_arbiter.sv
// 2:1 AXI4 arbiter sharing one memory channel between icache and dcache refill.
// AR/AW are registered round-robin; R/B route by prepended ID bit; W follows AW order.
module axi_mem_arbiter #(
    parameter int DW  = 128,
    parameter int AW  = 32,
    parameter int IDW = 3,
    parameter int WQ  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     m_ar_valid,
    output logic [1:0]                     m_ar_ready,
    input  logic [2*(IDW+AW+13)-1:0]       m_ar_bits,
    output logic [1:0]                     m_r_valid,
    input  logic [1:0]                     m_r_ready,
    output logic [IDW+DW+2:0]              m_r_bits,
    input  logic [1:0]                     m_aw_valid,
    output logic [1:0]                     m_aw_ready,
    input  logic [2*(IDW+AW+13)-1:0]       m_aw_bits,
    input  logic [1:0]                     m_w_valid,
    output logic [1:0]                     m_w_ready,
    input  logic [2*(DW+DW/8+1)-1:0]       m_w_bits,
    output logic [1:0]                     m_b_valid,
    input  logic [1:0]                     m_b_ready,
    output logic [IDW+1:0]                 m_b_bits,
    output logic                           s_ar_valid,
    input  logic                           s_ar_ready,
    output logic [IDW+AW+13:0]             s_ar_bits,
    input  logic                           s_r_valid,
    output logic                           s_r_ready,
    input  logic [IDW+DW+3:0]              s_r_bits,
    output logic                           s_aw_valid,
    input  logic                           s_aw_ready,
    output logic [IDW+AW+13:0]             s_aw_bits,
    output logic                           s_w_valid,
    input  logic                           s_w_ready,
    output logic [DW+DW/8:0]               s_w_bits,
    input  logic                           s_b_valid,
    output logic                           s_b_ready,
    input  logic [IDW+2:0]                 s_b_bits
);

    localparam int ABW = IDW + AW + 13;
    localparam int WBW = DW + DW / 8 + 1;
    localparam int PW  = (WQ > 1) ? $clog2(WQ) : 1;
    localparam int CW  = $clog2(WQ + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(WQ - 1)) ? '0 : p + 1'b1;
    endfunction

    logic           ar_valid_q, ar_valid_d;
    logic [ABW:0]   ar_bits_q, ar_bits_d;
    logic           ar_rr_q, ar_rr_d;
    logic           ar_free, ar_gnt, ar_hs;

    logic           aw_valid_q, aw_valid_d;
    logic [ABW:0]   aw_bits_q, aw_bits_d;
    logic           aw_rr_q, aw_rr_d;
    logic           aw_free, aw_gnt, aw_hs, aw_room;
    logic [CW:0]    aw_inflight;

    logic [WQ-1:0]  wq_mem_q, wq_mem_d;
    logic [PW-1:0]  wq_wp_q, wq_wp_d;
    logic [PW-1:0]  wq_rp_q, wq_rp_d;
    logic [CW-1:0]  wq_cnt_q, wq_cnt_d;
    logic           wq_push, wq_empty, w_head, w_pop;

    logic           r_sel, b_sel;

    always_comb begin
        ar_free    = ~ar_valid_q | s_ar_ready;
        ar_gnt     = m_ar_valid[ar_rr_q] ? ar_rr_q : ~ar_rr_q;
        m_ar_ready = 2'b00;
        m_ar_ready[ar_gnt] = ar_free & ~reset;
        ar_hs      = m_ar_valid[ar_gnt] & ar_free & ~reset;
        ar_valid_d = ar_valid_q & ~s_ar_ready;
        ar_bits_d  = ar_bits_q;
        ar_rr_d    = ar_rr_q;
        if (ar_hs) begin
            ar_valid_d = 1'b1;
            ar_bits_d  = {ar_gnt, ar_gnt ? m_ar_bits[2*ABW-1:ABW]
                                         : m_ar_bits[ABW-1:0]};
            ar_rr_d    = ~ar_gnt;
        end
    end

    // An AW still sitting in the output register will claim a FIFO slot too.
    always_comb begin
        aw_inflight = {1'b0, wq_cnt_q} + {{CW{1'b0}}, aw_valid_q};
        aw_room     = aw_inflight < (CW+1)'(WQ);
        aw_free     = (~aw_valid_q | s_aw_ready) & aw_room;
        aw_gnt      = m_aw_valid[aw_rr_q] ? aw_rr_q : ~aw_rr_q;
        m_aw_ready  = 2'b00;
        m_aw_ready[aw_gnt] = aw_free & ~reset;
        aw_hs       = m_aw_valid[aw_gnt] & aw_free & ~reset;
        aw_valid_d  = aw_valid_q & ~s_aw_ready;
        aw_bits_d   = aw_bits_q;
        aw_rr_d     = aw_rr_q;
        if (aw_hs) begin
            aw_valid_d = 1'b1;
            aw_bits_d  = {aw_gnt, aw_gnt ? m_aw_bits[2*ABW-1:ABW]
                                         : m_aw_bits[ABW-1:0]};
            aw_rr_d    = ~aw_gnt;
        end
    end

    always_comb begin
        wq_empty  = (wq_cnt_q == '0);
        w_head    = wq_mem_q[wq_rp_q];
        s_w_bits  = w_head ? m_w_bits[2*WBW-1:WBW] : m_w_bits[WBW-1:0];
        s_w_valid = 1'b0;
        m_w_ready = 2'b00;
        if (!wq_empty && !reset) begin
            s_w_valid         = m_w_valid[w_head];
            m_w_ready[w_head] = s_w_ready;
        end
        w_pop = s_w_valid & s_w_ready & s_w_bits[0];
    end

    always_comb begin
        wq_push  = aw_valid_q & s_aw_ready;
        wq_mem_d = wq_mem_q;
        wq_wp_d  = wq_wp_q;
        wq_rp_d  = wq_rp_q;
        wq_cnt_d = wq_cnt_q;
        if (wq_push) begin
            wq_mem_d[wq_wp_q] = aw_bits_q[ABW];
            wq_wp_d           = ptr_inc(wq_wp_q);
        end
        if (w_pop) begin
            wq_rp_d = ptr_inc(wq_rp_q);
        end
        unique case ({wq_push, w_pop})
            2'b10:   wq_cnt_d = wq_cnt_q + 1'b1;
            2'b01:   wq_cnt_d = wq_cnt_q - 1'b1;
            default: wq_cnt_d = wq_cnt_q;
        endcase
    end

    always_comb begin
        r_sel      = s_r_bits[IDW+DW+3];
        m_r_valid  = 2'b00;
        m_r_valid[r_sel] = s_r_valid & ~reset;
        s_r_ready  = m_r_ready[r_sel] & ~reset;
        m_r_bits   = s_r_bits[IDW+DW+2:0];
        b_sel      = s_b_bits[IDW+2];
        m_b_valid  = 2'b00;
        m_b_valid[b_sel] = s_b_valid & ~reset;
        s_b_ready  = m_b_ready[b_sel] & ~reset;
        m_b_bits   = s_b_bits[IDW+1:0];
    end

    assign s_ar_valid = ar_valid_q;
    assign s_ar_bits  = ar_bits_q;
    assign s_aw_valid = aw_valid_q;
    assign s_aw_bits  = aw_bits_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ar_valid_q <= 1'b0;
            ar_bits_q  <= '0;
            ar_rr_q    <= 1'b0;
            aw_valid_q <= 1'b0;
            aw_bits_q  <= '0;
            aw_rr_q    <= 1'b0;
            wq_mem_q   <= '0;
            wq_wp_q    <= '0;
            wq_rp_q    <= '0;
            wq_cnt_q   <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_bits_q  <= ar_bits_d;
            ar_rr_q    <= ar_rr_d;
            aw_valid_q <= aw_valid_d;
            aw_bits_q  <= aw_bits_d;
            aw_rr_q    <= aw_rr_d;
            wq_mem_q   <= wq_mem_d;
            wq_wp_q    <= wq_wp_d;
            wq_rp_q    <= wq_rp_d;
            wq_cnt_q   <= wq_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: arbitration order, routing,
// W ordering, FIFO back-pressure and reset recovery.
module tb_axi_mem_arbiter;

    localparam int ABW = 48;
    localparam int WBW = 145;

    logic               clock = 1'b0;
    logic               reset;
    logic [1:0]         m_ar_valid, m_ar_ready;
    logic [2*ABW-1:0]   m_ar_bits;
    logic [1:0]         m_r_valid, m_r_ready;
    logic [133:0]       m_r_bits;
    logic [1:0]         m_aw_valid, m_aw_ready;
    logic [2*ABW-1:0]   m_aw_bits;
    logic [1:0]         m_w_valid, m_w_ready;
    logic [2*WBW-1:0]   m_w_bits;
    logic [1:0]         m_b_valid, m_b_ready;
    logic [4:0]         m_b_bits;
    logic               s_ar_valid, s_ar_ready;
    logic [ABW:0]       s_ar_bits;
    logic               s_r_valid, s_r_ready;
    logic [134:0]       s_r_bits;
    logic               s_aw_valid, s_aw_ready;
    logic [ABW:0]       s_aw_bits;
    logic               s_w_valid, s_w_ready;
    logic [WBW-1:0]     s_w_bits;
    logic               s_b_valid, s_b_ready;
    logic [5:0]         s_b_bits;

    int n_tests = 0;
    int n_fail  = 0;

    axi_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits(m_ar_bits),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_bits(m_r_bits),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits(m_aw_bits),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_bits(m_w_bits),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits(m_b_bits),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits(s_ar_bits),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_bits(s_r_bits),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_bits(s_aw_bits),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_bits(s_w_bits),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_bits(s_b_bits)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ABW-1:0] mk_a(input logic [2:0] id,
                                            input logic [31:0] a,
                                            input logic [7:0] len);
        return {id, a, len, 3'd4, 2'b01};
    endfunction

    function automatic logic [WBW-1:0] mk_w(input logic [127:0] d,
                                            input logic last);
        return {d, 16'hffff, last};
    endfunction

    logic [ABW-1:0] a0, a1;
    logic [127:0]   d;
    logic [WBW-1:0] w0, w1a, w1b;
    int acc, saw, n0, n1, nsar;

    initial begin
        reset = 1'b1;
        m_ar_valid = 2'b00; m_ar_bits = '0; m_r_ready = 2'b00;
        m_aw_valid = 2'b00; m_aw_bits = '0;
        m_w_valid = 2'b00;  m_w_bits = '0;  m_b_ready = 2'b00;
        s_ar_ready = 1'b1; s_r_valid = 1'b0; s_r_bits = '0;
        s_aw_ready = 1'b1; s_w_ready = 1'b0;
        s_b_valid = 1'b0;  s_b_bits = '0;

        // reset state
        a0 = mk_a(3'd5, 32'h8000_0000, 8'd0);
        a1 = mk_a(3'd5, 32'h8000_0100, 8'd0);
        m_ar_bits  = {a1, a0};
        m_ar_valid = 2'b11;
        tick();
        tick();
        #1;
        chk("rst_ar_ready", m_ar_ready, 2'b00);
        chk("rst_s_ar_valid", s_ar_valid, 1'b0);
        chk("rst_s_aw_valid", s_aw_valid, 1'b0);
        chk("rst_s_w_valid", s_w_valid, 1'b0);
        chk("rst_m_w_ready", m_w_ready, 2'b00);
        chk("rst_m_r_valid", m_r_valid, 2'b00);
        chk("rst_m_b_valid", m_b_valid, 2'b00);

        // 1: simultaneous AR, m0 first then m1
        reset = 1'b0;
        #1;
        chk("t1_ready_c0", m_ar_ready, 2'b01);
        tick();
        chk("t1_valid_c1", s_ar_valid, 1'b1);
        chk("t1_bits_c1", s_ar_bits, {1'b0, a0});
        chk("t1_id_c1", s_ar_bits[ABW:ABW-3], 4'b0101);
        chk("t1_ready_c1", m_ar_ready, 2'b10);
        m_ar_valid = 2'b10;
        tick();
        chk("t1_valid_c2", s_ar_valid, 1'b1);
        chk("t1_bits_c2", s_ar_bits, {1'b1, a1});
        chk("t1_id_c2", s_ar_bits[ABW:ABW-3], 4'b1101);
        m_ar_valid = 2'b00;
        tick();
        chk("t1_idle", s_ar_valid, 1'b0);

        // 2: R routing with back-pressure from m1
        s_r_valid = 1'b1;
        m_r_ready = 2'b01;
        s_r_bits  = {4'b1010, 128'hA0, 2'b00, 1'b0};
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t2_stall_valid", m_r_valid, 2'b10);
            chk("t2_stall_ready", s_r_ready, 1'b0);
            tick();
        end
        m_r_ready = 2'b11;
        for (int b = 0; b < 4; b++) begin
            d = 128'hA0 + 128'(b);
            s_r_bits = {4'b1010, d, 2'b00, (b == 3)};
            #1;
            chk("t2_beat_valid", m_r_valid, 2'b10);
            chk("t2_beat_ready", s_r_ready, 1'b1);
            chk("t2_beat_bits", m_r_bits, {3'b010, d, 2'b00, (b == 3)});
            tick();
        end
        s_r_bits = {4'b0011, 128'h5, 2'b01, 1'b1};
        #1;
        chk("t2_m0_valid", m_r_valid, 2'b01);
        chk("t2_m0_bits", m_r_bits, {3'b011, 128'h5, 2'b01, 1'b1});
        s_r_valid = 1'b0;

        // B routing
        s_b_valid = 1'b1;
        s_b_bits  = {1'b1, 3'b010, 2'b10};
        m_b_ready = 2'b10;
        #1;
        chk("b_m1_valid", m_b_valid, 2'b10);
        chk("b_m1_ready", s_b_ready, 1'b1);
        chk("b_m1_bits", m_b_bits, {3'b010, 2'b10});
        s_b_bits = {1'b0, 3'b001, 2'b00};
        #1;
        chk("b_m0_valid", m_b_valid, 2'b01);
        chk("b_m0_ready", s_b_ready, 1'b0);
        s_b_valid = 1'b0;
        tick();

        // 3: W order follows AW grant order
        w0  = mk_w(128'hD0, 1'b1);
        w1a = mk_w(128'hD1A, 1'b0);
        w1b = mk_w(128'hD1B, 1'b1);
        s_w_ready  = 1'b1;
        m_aw_bits  = {mk_a(3'd2, 32'h4000, 8'd1), mk_a(3'd1, 32'h5000, 8'd0)};
        m_aw_valid = 2'b10;
        m_w_valid  = 2'b01;
        m_w_bits   = {w1a, w0};
        #1;
        chk("t3_aw1_ready", m_aw_ready, 2'b10);
        chk("t3_w_empty", s_w_valid, 1'b0);
        chk("t3_w_empty_rdy", m_w_ready, 2'b00);
        tick();
        m_aw_valid = 2'b01;
        #1;
        chk("t3_aw0_ready", m_aw_ready, 2'b01);
        chk("t3_w_before_push", m_w_ready, 2'b00);
        tick();
        m_aw_valid = 2'b00;
        #1;
        chk("t3_head_m1_valid", s_w_valid, 1'b0);
        chk("t3_head_m1_rdy", m_w_ready, 2'b10);
        tick();
        m_w_valid = 2'b11;
        #1;
        chk("t3_b0_valid", s_w_valid, 1'b1);
        chk("t3_b0_bits", s_w_bits, w1a);
        chk("t3_b0_rdy", m_w_ready, 2'b10);
        tick();
        m_w_bits = {w1b, w0};
        #1;
        chk("t3_b1_bits", s_w_bits, w1b);
        chk("t3_b1_rdy", m_w_ready, 2'b10);
        tick();
        m_w_valid = 2'b01;
        #1;
        chk("t3_m0_valid", s_w_valid, 1'b1);
        chk("t3_m0_bits", s_w_bits, w0);
        chk("t3_m0_rdy", m_w_ready, 2'b01);
        tick();
        #1;
        chk("t3_drained_valid", s_w_valid, 1'b0);
        chk("t3_drained_rdy", m_w_ready, 2'b00);
        m_w_valid = 2'b00;
        tick();

        // 4: W-owner FIFO depth limits outstanding AWs
        m_aw_bits = {mk_a(3'd0, 32'h0, 8'd0), mk_a(3'd1, 32'h9000_0000, 8'd1)};
        acc = 0;
        saw = 0;
        for (int c = 0; c < 8; c++) begin
            m_aw_valid = (acc < 6) ? 2'b01 : 2'b00;
            #1;
            if (m_aw_valid[0] && m_aw_ready[0]) acc++;
            if (s_aw_valid && s_aw_ready) saw++;
            tick();
        end
        chk("t4_accepted", acc, 4);
        chk("t4_s_aw_count", saw, 4);
        chk("t4_blocked", m_aw_ready, 2'b00);
        m_w_valid = 2'b01;
        m_w_bits  = {w1a, mk_w(128'hE0, 1'b1)};
        #1;
        chk("t4_still_blocked", m_aw_ready, 2'b00);
        chk("t4_w_rdy", m_w_ready, 2'b01);
        tick();
        m_w_valid = 2'b00;
        #1;
        chk("t4_unblocked", m_aw_ready, 2'b01);
        tick();
        m_aw_valid = 2'b00;

        // 5: back-to-back AR alternation
        m_ar_bits = {mk_a(3'd1, 32'h2000, 8'd0), mk_a(3'd0, 32'h1000, 8'd0)};
        n0 = 0;
        n1 = 0;
        nsar = 0;
        for (int c = 0; c < 18; c++) begin
            m_ar_valid = {(n1 < 8), (n0 < 8)};
            #1;
            chk("t5_s_ar_valid", s_ar_valid, (c >= 1 && c <= 16));
            if (s_ar_valid) begin
                chk("t5_alt_msb", s_ar_bits[ABW], nsar % 2);
                nsar++;
            end
            if (m_ar_valid[0] && m_ar_ready[0]) n0++;
            if (m_ar_valid[1] && m_ar_ready[1]) n1++;
            tick();
        end
        chk("t5_total", nsar, 16);
        m_ar_valid = 2'b00;

        // 6: reset in the middle of a W burst
        s_ar_ready = 1'b0;
        m_ar_valid = 2'b01;
        m_w_valid  = 2'b01;
        m_w_bits   = {w1a, mk_w(128'hF0, 1'b0)};
        #1;
        chk("t6_w_beat0", s_w_valid, 1'b1);
        chk("t6_ar_m0", m_ar_ready, 2'b01);
        tick();
        chk("t6_ar_held", s_ar_valid, 1'b1);
        m_w_bits   = {w1a, mk_w(128'hF1, 1'b1)};
        m_ar_valid = 2'b11;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        s_ar_ready = 1'b1;
        m_w_valid  = 2'b11;
        m_aw_valid = 2'b01;
        #1;
        chk("t6_s_ar_valid", s_ar_valid, 1'b0);
        chk("t6_s_aw_valid", s_aw_valid, 1'b0);
        chk("t6_s_w_valid", s_w_valid, 1'b0);
        chk("t6_m_w_ready", m_w_ready, 2'b00);
        chk("t6_ar_grant_m0", m_ar_ready, 2'b01);
        chk("t6_aw_room", m_aw_ready, 2'b01);
        m_aw_valid = 2'b00;
        tick();
        chk("t6_after_valid", s_ar_valid, 1'b1);
        chk("t6_after_msb", s_ar_bits[ABW], 1'b0);
        m_ar_valid = 2'b00;
        m_w_valid  = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
